// File: rtl/sensores_pkg.sv
// Shared FSM encoding, default thresholds and the hysteresis rule for the sensor front end.
package sensores_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        INICIO  = 2'd1,
        LECTURA = 2'd2,
        FIN     = 2'd3
    } estado_t;

    localparam int UMBRAL_ALTO_DEF = 60;
    localparam int UMBRAL_BAJO_DEF = 55;

    // Values strictly inside the band keep the previous flag.
    function automatic logic histeresis(
        input logic [31:0] t,
        input logic        prev,
        input logic [31:0] alto,
        input logic [31:0] bajo
    );
        logic r;
        r = prev;
        if (t >= alto) begin
            r = 1'b1;
        end else if (t <= bajo) begin
            r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/filtro_hn.sv
// Presence debounce: 2-FF synchronizer then N_FILTRO-cycle stability filter.
// hn follows a stable hn_crudo edge after N_FILTRO + 2 cycles.
module filtro_hn #(
    parameter int N_FILTRO = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hn_crudo,
    output logic hn
);

    localparam int            CW      = $clog2(N_FILTRO) + 1;
    localparam logic [CW-1:0] CNT_FIN = CW'(N_FILTRO - 1);

    logic          sinc1_q;
    logic          sinc2_q;
    logic          hn_q;
    logic [CW-1:0] cnt_q;

    // cnt_q holds the mismatching cycles already seen, so the N_FILTRO-th one flips hn.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sinc1_q <= 1'b0;
            sinc2_q <= 1'b0;
            hn_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sinc1_q <= hn_crudo;
            sinc2_q <= sinc1_q;
            if (sinc2_q == hn_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_FIN) begin
                cnt_q <= '0;
                hn_q  <= sinc2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign hn = hn_q;

endmodule

// File: rtl/lect_sensores.sv
// Periodic serial temperature read with hysteresis flag, plus debounced presence.
// cs_n low DIV + 2*DIV*N_BITS cycles per read; temp/temp_alta/dato_listo update as cs_n rises.
module lect_sensores
    import sensores_pkg::*;
#(
    parameter int DIV         = 4,
    parameter int N_BITS      = 8,
    parameter int T_ESPERA    = 50_000_000,
    parameter int UMBRAL_ALTO = UMBRAL_ALTO_DEF,
    parameter int UMBRAL_BAJO = UMBRAL_BAJO_DEF,
    parameter int N_FILTRO    = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EN,
    input  logic              sdo,
    input  logic              hn_crudo,
    output logic              cs_n,
    output logic              sclk,
    output logic [N_BITS-1:0] temp,
    output logic              temp_alta,
    output logic              hn,
    output logic              dato_listo
);

    localparam int ESP_W = $clog2(T_ESPERA) + 1;
    localparam int DIV_W = $clog2(DIV) + 1;
    localparam int BIT_W = $clog2(N_BITS) + 1;

    localparam logic [ESP_W-1:0] ESP_FIN = ESP_W'(T_ESPERA - 1);
    localparam logic [DIV_W-1:0] DIV_FIN = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_FIN = BIT_W'(N_BITS - 1);

    estado_t           estado_q;
    logic [ESP_W-1:0]  esp_q;
    logic [DIV_W-1:0]  div_q;
    logic [BIT_W-1:0]  bit_q;
    logic [N_BITS-1:0] sh_q;
    logic [N_BITS-1:0] temp_q;
    logic              cs_n_q;
    logic              sclk_q;
    logic              alta_q;
    logic              listo_q;
    logic              alta_d;

    assign alta_d = histeresis(32'(sh_q), alta_q, 32'(UMBRAL_ALTO), 32'(UMBRAL_BAJO));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            esp_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            temp_q   <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            alta_q   <= 1'b0;
            listo_q  <= 1'b0;
        end else if (!EN) begin
            // Abort: drop the bus and restart the idle wait; results keep their last value.
            estado_q <= REPOSO;
            esp_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            listo_q  <= 1'b0;
        end else begin
            listo_q <= 1'b0;
            case (estado_q)
                REPOSO: begin
                    if (esp_q == ESP_FIN) begin
                        esp_q    <= '0;
                        cs_n_q   <= 1'b0;
                        estado_q <= INICIO;
                    end else begin
                        esp_q <= esp_q + ESP_W'(1);
                    end
                end
                INICIO: begin
                    if (div_q == DIV_FIN) begin
                        div_q    <= '0;
                        estado_q <= LECTURA;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                LECTURA: begin
                    if (div_q != DIV_FIN) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            sh_q   <= (sh_q << 1) | N_BITS'(sdo);
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == BIT_FIN) begin
                                // Last high phase done: this edge is the FIN cycle's outputs.
                                bit_q    <= '0;
                                cs_n_q   <= 1'b1;
                                temp_q   <= sh_q;
                                alta_q   <= alta_d;
                                listo_q  <= 1'b1;
                                estado_q <= FIN;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                            end
                        end
                    end
                end
                FIN: begin
                    estado_q <= REPOSO;
                end
                default: begin
                    estado_q <= REPOSO;
                end
            endcase
        end
    end

    filtro_hn #(
        .N_FILTRO(N_FILTRO)
    ) u_filtro_hn (
        .clk      (clk),
        .rst_n    (rst_n),
        .hn_crudo (hn_crudo),
        .hn       (hn)
    );

    assign cs_n       = cs_n_q;
    assign sclk       = sclk_q;
    assign temp       = temp_q;
    assign temp_alta  = alta_q;
    assign dato_listo = listo_q;

endmodule

// File: tb/tb_lect_sensores.sv
// Bench for lect_sensores: serial sensor model, scoreboard on dato_listo, directed corner sequences.
module tb_lect_sensores;

    localparam int DIV     = 2;
    localparam int NB      = 8;
    localparam int T_ESP   = 16;
    localparam int UA      = 60;
    localparam int UB      = 55;
    localparam int NF      = 4;
    localparam int CS_LOW  = DIV + 2 * DIV * NB;
    localparam int PERIODO = T_ESP + CS_LOW + 1;
    localparam int HN_LAT  = NF + 2;
    localparam int NV      = 12;

    typedef struct {
        logic [7:0] word;
        logic       alta;
    } vec_t;

    typedef struct packed {
        logic [7:0] word;
        logic       alta;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          EN;
    logic          sdo = 1'b0;
    logic          hn_crudo;
    logic          cs_n;
    logic          sclk;
    logic [NB-1:0] temp;
    logic          temp_alta;
    logic          hn;
    logic          dato_listo;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         listo_cnt = 0;
    int         listo_cyc = 0;
    logic [7:0] sens_word = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    lect_sensores #(
        .DIV        (DIV),
        .N_BITS     (NB),
        .T_ESPERA   (T_ESP),
        .UMBRAL_ALTO(UA),
        .UMBRAL_BAJO(UB),
        .N_FILTRO   (NF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EN        (EN),
        .sdo       (sdo),
        .hn_crudo  (hn_crudo),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .temp      (temp),
        .temp_alta (temp_alta),
        .hn        (hn),
        .dato_listo(dato_listo)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    // Sensor: presents the next bit after each sclk fall, MSB first, restarting when deselected.
    int   sidx = 0;
    logic sm_prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (cs_n !== 1'b0) begin
            sidx = 0;
        end else if (sm_prev_sclk && !sclk) begin
            sidx++;
        end
        sm_prev_sclk = sclk;
        sdo = (sidx < NB) ? sens_word[NB-1-sidx] : 1'b0;
    end

    // Bus monitor and scoreboard pop.
    int   low_len = 0;
    int   pulses = 0;
    int   hi_run = 0;
    int   hi_min = 1000;
    int   hi_max = 0;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;
    logic prev_listo = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (cs_n === 1'b0) begin
            if (prev_cs) begin
                low_len = 0;
                pulses  = 0;
                hi_min  = 1000;
                hi_max  = 0;
            end
            low_len++;
        end
        if (sclk === 1'b1) begin
            if (!prev_sclk) begin
                pulses++;
                hi_run = 0;
            end
            hi_run++;
        end else if (prev_sclk) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
        end
        if (prev_listo) chk("listo_one_cycle", 32'(dato_listo), 32'd0);
        if (dato_listo === 1'b1) begin
            listo_cnt++;
            listo_cyc = cyc;
            chk("listo_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("temp", 32'(temp), 32'(e.word));
                chk("temp_alta", 32'(temp_alta), 32'(e.alta));
                chk("cs_n_at_listo", 32'(cs_n), 32'd1);
                chk("cs_low_len", 32'(low_len), 32'(CS_LOW));
                chk("sclk_pulses", 32'(pulses), 32'(NB));
                chk("sclk_hi_min", 32'(hi_min), 32'(DIV));
                chk("sclk_hi_max", 32'(hi_max), 32'(DIV));
            end
        end
        prev_cs    = (cs_n === 1'b0) ? 1'b0 : 1'b1;
        prev_sclk  = (sclk === 1'b1);
        prev_listo = (dato_listo === 1'b1);
    end

    task automatic wait_listo(input string nm);
        int  start;
        bit  got;
        start = listo_cnt;
        got   = 1'b0;
        for (int k = 0; k < 4 * PERIODO; k++) begin
            @(posedge clk);
            if (listo_cnt != start) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, "_arrived"}, 32'(got), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_cs_fall(input int exp_cyc, input string nm);
        int n;
        n = -1;
        for (int k = 1; k <= 4 * PERIODO; k++) begin
            @(negedge clk);
            if (cs_n === 1'b0) begin
                n = k;
                break;
            end
        end
        chk(nm, 32'(n), 32'(exp_cyc));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_cs_n"}, 32'(cs_n), 32'd1);
        chk({nm, "_sclk"}, 32'(sclk), 32'd0);
        chk({nm, "_temp"}, 32'(temp), 32'd0);
        chk({nm, "_temp_alta"}, 32'(temp_alta), 32'd0);
        chk({nm, "_hn"}, 32'(hn), 32'd0);
        chk({nm, "_dato_listo"}, 32'(dato_listo), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin : main
        vec_t tbl[NV];
        int   prev_cyc;
        int   ns;
        int   n;
        logic ps;
        bit   seen;

        // Expected flag depends on the previous word inside the 56..59 band.
        tbl[0]  = '{8'h3E, 1'b1};
        tbl[1]  = '{8'h39, 1'b1};
        tbl[2]  = '{8'h37, 1'b0};
        tbl[3]  = '{8'h3A, 1'b0};
        tbl[4]  = '{8'h3C, 1'b1};
        tbl[5]  = '{8'h00, 1'b0};
        tbl[6]  = '{8'hFF, 1'b1};
        tbl[7]  = '{8'h01, 1'b0};
        tbl[8]  = '{8'h80, 1'b1};
        tbl[9]  = '{8'h3B, 1'b1};
        tbl[10] = '{8'h38, 1'b1};
        tbl[11] = '{8'h37, 1'b0};

        rst_n    = 1'b0;
        EN       = 1'b0;
        hn_crudo = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");

        sens_word = tbl[0].word;
        exp_q.push_back('{tbl[0].word, tbl[0].alta});
        rst_n = 1'b1;
        EN    = 1'b1;
        wait_cs_fall(T_ESP, "first_cs_fall");
        wait_listo("read0");
        for (int i = 1; i < NV; i++) begin
            prev_cyc  = listo_cyc;
            sens_word = tbl[i].word;
            exp_q.push_back('{tbl[i].word, tbl[i].alta});
            wait_listo("read_tbl");
            chk("read_period", 32'(listo_cyc - prev_cyc), 32'(PERIODO));
        end

        // Abort on the 4th sclk pulse.
        sens_word = 8'h5A;
        ns = 0;
        ps = 1'b0;
        for (int k = 0; k < 4 * PERIODO; k++) begin
            @(negedge clk);
            if (cs_n === 1'b0 && sclk === 1'b1 && !ps) ns++;
            ps = (sclk === 1'b1);
            if (ns == 4) break;
        end
        chk("abort_reached_pulse4", 32'(ns), 32'd4);
        EN = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", 32'(cs_n), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_temp", 32'(temp), 32'(tbl[NV-1].word));
        chk("abort_temp_alta", 32'(temp_alta), 32'(tbl[NV-1].alta));
        chk("abort_listo", 32'(dato_listo), 32'd0);
        repeat (30) @(negedge clk);
        chk("abort_idle_cs_n", 32'(cs_n), 32'd1);
        sens_word = 8'h3D;
        exp_q.push_back('{8'h3D, 1'b1});
        EN = 1'b1;
        wait_cs_fall(T_ESP, "abort_restart_cs_fall");
        wait_listo("abort_restart_read");

        // One-cycle reset during LECTURA.
        sens_word = 8'hC3;
        wait_cs_fall(T_ESP, "pre_reset_cs_fall");
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midreset");
        sens_word = 8'hB4;
        exp_q.push_back('{8'hB4, 1'b1});
        rst_n = 1'b1;
        wait_cs_fall(T_ESP, "reset_restart_cs_fall");
        wait_listo("reset_restart_read");

        // Presence debounce, with reads disabled.
        EN       = 1'b0;
        hn_crudo = 1'b1;
        repeat (3) @(negedge clk);
        hn_crudo = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (hn === 1'b1) seen = 1'b1;
        end
        chk("hn_glitch_ignored", 32'(seen), 32'd0);

        hn_crudo = 1'b1;
        n = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (hn === 1'b1) begin
                n = k;
                break;
            end
        end
        chk("hn_rise_latency", 32'(n), 32'(HN_LAT));
        repeat (5) @(negedge clk);
        chk("hn_held_high", 32'(hn), 32'd1);

        hn_crudo = 1'b0;
        n = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (hn === 1'b0) begin
                n = k;
                break;
            end
        end
        chk("hn_fall_latency", 32'(n), 32'(HN_LAT));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
